// File: rtl/dsm_bridge_driver_if.sv
// Bus between the delta-sigma modulator side and the H-bridge gate driver:
// code/control inputs in, four gate drives and status flags out.
interface dsm_bridge_driver_if;
  logic [1:0] pwm;
  logic       enable;
  logic       fault;
  logic       fault_clr;
  logic       hi_a;
  logic       lo_a;
  logic       hi_b;
  logic       lo_b;
  logic       fault_flag;
  logic       code_err;

  modport master (
    output pwm, enable, fault, fault_clr,
    input  hi_a, lo_a, hi_b, lo_b, fault_flag, code_err
  );

  modport slave (
    input  pwm, enable, fault, fault_clr,
    output hi_a, lo_a, hi_b, lo_b, fault_flag, code_err
  );
endinterface

// File: rtl/dsm_bridge_driver.sv
// Full H-bridge gate driver fed by a three-level modulator code. Each leg runs
// its own OFF/LO/HI/DEAD machine with break-before-make dead time and min on-time.
module dsm_bridge_driver #(
  parameter int DEAD   = 4,
  parameter int MIN_ON = 8,
  parameter int CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  dsm_bridge_driver_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DEAD = 2'd3
  } leg_state_e;

  localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD - 1);
  localparam logic [CNT_W-1:0] MINON_LD = CNT_W'(MIN_ON - 1);

  logic [1:0] pwm_q;
  logic       code_err_q;
  logic       fault_flag_q;
  logic       fault_flag_d;
  logic       kill;
  logic [1:0] target_hi;
  logic [1:0] hi_g;
  logic [1:0] lo_g;

  // Set dominates clear so a persisting fault can never be cleared away.
  assign fault_flag_d = bus.fault | (fault_flag_q & ~bus.fault_clr);

  // Raw fault is included so the gates drop on the same edge that latches the flag.
  assign kill = ~bus.enable | fault_flag_q | bus.fault;

  assign target_hi[0] = (pwm_q == 2'b01);
  assign target_hi[1] = (pwm_q == 2'b11);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_q        <= 2'b00;
      code_err_q   <= 1'b0;
      fault_flag_q <= 1'b0;
    end else begin
      pwm_q        <= bus.pwm;
      code_err_q   <= (bus.pwm == 2'b10);
      fault_flag_q <= fault_flag_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_leg
      leg_state_e       state_q;
      leg_state_e       state_d;
      leg_state_e       target_side;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             hi_q;
      logic             lo_q;
      logic             hi_d;
      logic             lo_d;

      assign target_side = target_hi[gi] ? ST_HI : ST_LO;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
          hi_q    <= 1'b0;
          lo_q    <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          hi_q    <= hi_d;
          lo_q    <= lo_d;
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (kill) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          case (state_q)
            ST_OFF: begin
              state_d = target_side;
              cnt_d   = MINON_LD;
            end
            ST_LO, ST_HI: begin
              if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else if (target_side != state_q) begin
                state_d = ST_DEAD;
                cnt_d   = DEAD_LD;
              end
            end
            ST_DEAD: begin
              // Dead time always runs to completion, even if the target reverted.
              if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
              end else begin
                state_d = target_side;
                cnt_d   = MINON_LD;
              end
            end
            default: begin
              state_d = ST_OFF;
              cnt_d   = '0;
            end
          endcase
        end
      end

      always_comb begin
        hi_d = (state_d == ST_HI);
        lo_d = (state_d == ST_LO);
      end

      assign hi_g[gi] = hi_q;
      assign lo_g[gi] = lo_q;
    end
  endgenerate

  assign bus.hi_a       = hi_g[0];
  assign bus.lo_a       = lo_g[0];
  assign bus.hi_b       = hi_g[1];
  assign bus.lo_b       = lo_g[1];
  assign bus.fault_flag = fault_flag_q;
  assign bus.code_err   = code_err_q;

endmodule

// File: tb/tb_dsm_bridge_driver.sv
// Scenario bench for dsm_bridge_driver: expected output vectors are queued as
// stimulus is applied and popped after each clock edge.
module tb_dsm_bridge_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;

  dsm_bridge_driver_if bus ();

  dsm_bridge_driver #(.DEAD(4), .MIN_ON(8), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [5:0] got;
  int         checks = 0;
  int         passes = 0;

  // Vector layout: {hi_a, lo_a, hi_b, lo_b, fault_flag, code_err}
  function automatic logic [5:0] pk(input logic ha, la, hb, lb, ff, ce);
    return {ha, la, hb, lb, ff, ce};
  endfunction

  function automatic logic [5:0] outs();
    return {bus.hi_a, bus.lo_a, bus.hi_b, bus.lo_b, bus.fault_flag, bus.code_err};
  endfunction

  task automatic settle_lo();
    bus.pwm = 2'b00; bus.enable = 1'b1; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    repeat (25) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    bus.pwm = 2'b10; bus.enable = 1'b1; bus.fault = 1'b0; bus.fault_clr = 1'b0;
    sb.push_back('{"reset_state", pk(0, 0, 0, 0, 0, 0)});
    repeat (2) @(posedge clock);
    #1;
    e = sb.pop_front(); got = outs(); checks++;
    if (got !== e.v) $display("FAIL %s got=%b want=%b", e.tag, got, e.v); else passes++;
    bus.pwm = 2'b00;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) sb.push_back('{"reset_release_lo", pk(0, 1, 0, 1, 0, 0)});
      @(posedge clock); #1;
      if (c == 1) begin
        e = sb.pop_front(); got = outs(); checks++;
        if (got !== e.v) $display("FAIL %s got=%b want=%b", e.tag, got, e.v); else passes++;
      end
    end
  endtask

  task automatic test_pos_step();
    settle_lo();
    for (int c = 0; c < 13; c++) begin
      bus.pwm = 2'b01;
      sb.push_back('{"pos_step", pk(c >= 5, c == 0, 0, 1, 0, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_min_on();
    settle_lo();
    for (int c = 0; c < 20; c++) begin
      bus.pwm = (c < 6) ? 2'b01 : 2'b00;
      sb.push_back('{"min_on", pk(c >= 5 && c <= 12, c == 0 || c >= 17, 0, 1, 0, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_revert_dead();
    settle_lo();
    for (int c = 0; c < 10; c++) begin
      bus.pwm = (c < 2) ? 2'b01 : 2'b00;
      sb.push_back('{"revert_dead", pk(0, c == 0 || c >= 5, 0, 1, 0, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_swing();
    settle_lo();
    for (int c = 0; c < 23; c++) begin
      bus.pwm = (c < 14) ? 2'b11 : 2'b01;
      if (c < 15)
        sb.push_back('{"swing", pk(0, 1, c >= 5, c == 0, 0, 0)});
      else if (c < 19)
        sb.push_back('{"swing", pk(0, 0, 0, 0, 0, 0)});
      else
        sb.push_back('{"swing", pk(1, 0, 0, 1, 0, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_enable();
    settle_lo();
    for (int c = 0; c < 6; c++) begin
      bus.pwm = 2'b01;
      bus.enable = !(c == 2 || c == 3);
      if (c == 0)      sb.push_back('{"enable", pk(0, 1, 0, 1, 0, 0)});
      else if (c == 1) sb.push_back('{"enable", pk(0, 0, 0, 1, 0, 0)});
      else if (c < 4)  sb.push_back('{"enable", pk(0, 0, 0, 0, 0, 0)});
      else             sb.push_back('{"enable", pk(1, 0, 0, 1, 0, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_fault();
    logic on, flag;
    settle_lo();
    bus.pwm = 2'b01;
    repeat (8) @(posedge clock);
    #1;
    for (int c = 0; c < 11; c++) begin
      bus.fault     = (c == 0 || c == 7);
      bus.fault_clr = (c == 4 || c == 7 || c == 9);
      on   = (c == 5 || c == 6 || c == 10);
      flag = (c < 4 || c == 7 || c == 8);
      sb.push_back('{"fault", pk(on, 0, 0, on, flag, 0)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
    bus.fault = 1'b0; bus.fault_clr = 1'b0;
  endtask

  task automatic test_illegal_code();
    settle_lo();
    for (int c = 0; c < 6; c++) begin
      bus.pwm = (c < 3) ? 2'b10 : 2'b00;
      sb.push_back('{"illegal_code", pk(0, 1, 0, 1, 0, c < 3)});
      @(posedge clock); #1;
      e = sb.pop_front(); got = outs(); checks++;
      if (got !== e.v) $display("FAIL %s cyc%0d got=%b want=%b", e.tag, c, got, e.v); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    settle_lo();
    bus.pwm = 2'b01;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    sb.push_back('{"reset_async_mid_dead", pk(0, 0, 0, 0, 0, 0)});
    #1;
    e = sb.pop_front(); got = outs(); checks++;
    if (got !== e.v) $display("FAIL %s got=%b want=%b", e.tag, got, e.v); else passes++;
    bus.pwm = 2'b00;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    sb.push_back('{"reset_mid_recover", pk(0, 1, 0, 1, 0, 0)});
    repeat (2) @(posedge clock);
    #1;
    e = sb.pop_front(); got = outs(); checks++;
    if (got !== e.v) $display("FAIL %s got=%b want=%b", e.tag, got, e.v); else passes++;
  endtask

  initial begin
    test_reset();
    test_pos_step();
    test_min_on();
    test_revert_dead();
    test_swing();
    test_enable();
    test_fault();
    test_illegal_code();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
